// File: rtl/cpu_reset_seq.sv
// Cortex-M reset sequencer: qualifies clock-mux lock, then releases PORESETn, then SYSRESETn.
// Optional macro CPU_SYSRESETREQ_EN lets a rising SYSRESETREQ act like host_sys_req in RUN.
// Latency: numbering the first clk_cpu edge that samples locked high as edge 1, cpu_poreset_n
// rises after edge SYNC_STAGES+LOCK_STABLE_CYCLES+POR_HOLD_CYCLES, and reset_done rises
// after edge SYNC_STAGES+LOCK_STABLE_CYCLES+POR_HOLD_CYCLES+SYS_HOLD_CYCLES (the +0 case).
module cpu_reset_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned POR_HOLD_CYCLES    = 16,
  parameter int unsigned SYS_HOLD_CYCLES    = 8,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic clk_cpu,
  input  logic reset,
  input  logic locked,
  input  logic host_por_req,
  input  logic host_sys_req,
  input  logic cpu_sysresetreq,
  output logic cpu_poreset_n,
  output logic cpu_sysreset_n,
  output logic reset_done,
  output logic lock_lost
);

  localparam int unsigned MAX_PS  = (POR_HOLD_CYCLES > SYS_HOLD_CYCLES) ? POR_HOLD_CYCLES : SYS_HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (LOCK_STABLE_CYCLES > MAX_PS) ? LOCK_STABLE_CYCLES : MAX_PS;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] POR_LAST  = CW'(POR_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SYS_LAST  = CW'(SYS_HOLD_CYCLES - 1);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] PO_HOLD   = 2'd1;
  localparam logic [1:0] SYS_HOLD  = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  logic [1:0]             state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx, cnt_inc;
  logic                   lost_nx;
  logic                   sys_req;

  always_ff @(posedge clk_cpu) begin
    if (reset) lock_sync <= '0;
    else       lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
  end
  assign lock_s = lock_sync[SYNC_STAGES-1];

`ifdef CPU_SYSRESETREQ_EN
  logic req_q, req_prev;

  // req_prev resets high so a request already asserted out of reset is not seen as an edge
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      req_q    <= 1'b0;
      req_prev <= 1'b1;
    end else begin
      req_q    <= cpu_sysresetreq;
      req_prev <= req_q;
    end
  end
  assign sys_req = host_sys_req | (req_q & ~req_prev);
`else
  logic unused_sysresetreq;
  assign unused_sysresetreq = cpu_sysresetreq;
  assign sys_req            = host_sys_req;
`endif

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_inc;
    lost_nx  = lock_lost;
    case (state)
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_nx = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nx = PO_HOLD;
          cnt_nx   = '0;
        end
      end
      PO_HOLD: begin
        if (cnt == POR_LAST) begin
          state_nx = SYS_HOLD;
          cnt_nx   = '0;
        end
      end
      SYS_HOLD: begin
        if (cnt == SYS_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      default: cnt_nx = '0;
    endcase

    // Event overrides, highest priority first
    if (state != WAIT_LOCK && !lock_s) begin
      state_nx = WAIT_LOCK;
      cnt_nx   = '0;
      lost_nx  = 1'b1;
    end else if (host_por_req) begin
      state_nx = WAIT_LOCK;
      cnt_nx   = '0;
    end else if (state == RUN && sys_req) begin
      state_nx = SYS_HOLD;
      cnt_nx   = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state          <= WAIT_LOCK;
      cnt            <= '0;
      lock_lost      <= 1'b0;
      cpu_poreset_n  <= 1'b0;
      cpu_sysreset_n <= 1'b0;
      reset_done     <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      lock_lost      <= lost_nx;
      cpu_poreset_n  <= (state_nx == SYS_HOLD) || (state_nx == RUN);
      cpu_sysreset_n <= (state_nx == RUN);
      reset_done     <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_cpu_reset_seq.sv
// Bench for cpu_reset_seq: timeline model compared every cycle, plus directed latency checks.
module tb_cpu_reset_seq;

  localparam int L = 8;
  localparam int P = 4;
  localparam int S = 3;
  localparam int N = 2;

  logic clk_cpu = 1'b0;
  logic reset = 1'b1;
  logic locked = 1'b0;
  logic host_por_req = 1'b0;
  logic host_sys_req = 1'b0;
  logic cpu_sysresetreq = 1'b0;
  logic cpu_poreset_n, cpu_sysreset_n, reset_done, lock_lost;

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b0;

  always #5 clk_cpu = ~clk_cpu;

  cpu_reset_seq #(
    .LOCK_STABLE_CYCLES(L),
    .POR_HOLD_CYCLES(P),
    .SYS_HOLD_CYCLES(S),
    .SYNC_STAGES(N)
  ) dut (
    .clk_cpu(clk_cpu),
    .reset(reset),
    .locked(locked),
    .host_por_req(host_por_req),
    .host_sys_req(host_sys_req),
    .cpu_sysresetreq(cpu_sysresetreq),
    .cpu_poreset_n(cpu_poreset_n),
    .cpu_sysreset_n(cpu_sysreset_n),
    .reset_done(reset_done),
    .lock_lost(lock_lost)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: m_wait = still qualifying lock (m_run consecutive lock highs);
  // otherwise m_e = edges elapsed since lock was qualified, saturating at P+S.
  logic [N-1:0] m_hist = '0;
  bit m_wait = 1'b1;
  int m_run  = 0;
  int m_e    = 0;
  bit m_lost = 1'b0;
  bit m_q    = 1'b0;
  bit m_prev = 1'b1;
  bit m_ls, m_sys;

  always @(posedge clk_cpu) begin
    if (reset) begin
      m_hist = '0; m_wait = 1'b1; m_run = 0; m_e = 0; m_lost = 1'b0;
      m_q = 1'b0; m_prev = 1'b1;
    end else begin
      m_ls  = m_hist[N-1];
      m_sys = host_sys_req;
`ifdef CPU_SYSRESETREQ_EN
      m_sys  = m_sys | (m_q & !m_prev);
      m_prev = m_q;
      m_q    = cpu_sysresetreq;
`endif
      if (m_wait) begin
        if (host_por_req || !m_ls) m_run = 0;
        else m_run++;
        if (m_run == L) begin m_wait = 1'b0; m_e = 0; end
      end else if (!m_ls) begin
        m_wait = 1'b1; m_run = 0; m_lost = 1'b1;
      end else if (host_por_req) begin
        m_wait = 1'b1; m_run = 0;
      end else if (m_sys && m_e >= P + S) begin
        m_e = P;
      end else if (m_e < P + S) begin
        m_e++;
      end
      m_hist = {m_hist[N-2:0], locked};
    end
  end

  always @(negedge clk_cpu) begin
    if (cmp_en) begin
      chk("cmp_poreset_n",  cpu_poreset_n,  !m_wait && m_e >= P);
      chk("cmp_sysreset_n", cpu_sysreset_n, !m_wait && m_e >= P + S);
      chk("cmp_reset_done", reset_done,     !m_wait && m_e >= P + S);
      chk("cmp_lock_lost",  lock_lost,      m_lost);
    end
  end

  task automatic do_reset();
    @(negedge clk_cpu);
    reset = 1'b1; locked = 1'b0; host_por_req = 1'b0; host_sys_req = 1'b0; cpu_sysresetreq = 1'b0;
    repeat (3) @(negedge clk_cpu);
    chk("rst_poreset_n", cpu_poreset_n, 0);
    chk("rst_sysreset_n", cpu_sysreset_n, 0);
    chk("rst_reset_done", reset_done, 0);
    chk("rst_lock_lost", lock_lost, 0);
    reset = 1'b0;
  endtask

  // Edge 1 is the first edge after the caller's stimulus; one-cycle pulses are cleared after it
  task automatic measure(input int maxk, output int k_po, output int k_done);
    k_po = -1; k_done = -1;
    for (int k = 1; k <= maxk; k++) begin
      @(posedge clk_cpu); #1;
      host_por_req = 1'b0; host_sys_req = 1'b0;
      if (k_po < 0 && cpu_poreset_n) k_po = k;
      if (reset_done) begin k_done = k; break; end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_cpu); #1;
      if (reset_done) return;
    end
    chk("wait_done_timeout", 0, 1);
  endtask

  int kp, kd, lows, po_lows, falls;
  logic prev_sys;

  initial begin
    @(posedge clk_cpu);
    cmp_en = 1'b1;

    // 1: clean power-up
    do_reset();
    repeat (5) @(negedge clk_cpu);
    locked = 1'b1;
    measure(60, kp, kd);
    chk("s1_po_latency", kp, N + L + P);
    chk("s1_done_latency", kd, N + L + P + S);
    chk("s1_lock_lost", lock_lost, 0);

    // 2: one-cycle dropout while qualifying
    do_reset();
    @(negedge clk_cpu); locked = 1'b1;
    repeat (5) @(negedge clk_cpu); locked = 1'b0;
    @(negedge clk_cpu); locked = 1'b1;
    measure(60, kp, kd);
    chk("s2_po_latency", kp, N + L + P);
    chk("s2_done_latency", kd, N + L + P + S);

    // 3: lock loss in RUN
    @(negedge clk_cpu); locked = 1'b0;
    @(posedge clk_cpu); #1;
    @(negedge clk_cpu); locked = 1'b1;
    @(posedge clk_cpu); #1;
    chk("s3_po_k2", cpu_poreset_n, 1);
    @(posedge clk_cpu); #1;
    chk("s3_po_k3", cpu_poreset_n, 0);
    chk("s3_sys_k3", cpu_sysreset_n, 0);
    chk("s3_done_k3", reset_done, 0);
    chk("s3_lost_k3", lock_lost, 1);
    wait_done();
    chk("s3_lost_after_reseq", lock_lost, 1);
    do_reset();
    @(negedge clk_cpu); locked = 1'b1;
    wait_done();

    // 4: host system-only reset
    @(negedge clk_cpu); host_sys_req = 1'b1;
    lows = 0; po_lows = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_cpu); #1;
      host_sys_req = 1'b0;
      if (!cpu_sysreset_n) lows++;
      if (!cpu_poreset_n) po_lows++;
    end
    chk("s4_sys_low_cycles", lows, S);
    chk("s4_po_low_cycles", po_lows, 0);

    // 5: host_por_req with host_sys_req during PO_HOLD
    do_reset();
    @(negedge clk_cpu); locked = 1'b1;
    repeat (11) @(negedge clk_cpu);
    host_por_req = 1'b1; host_sys_req = 1'b1;
    measure(60, kp, kd);
    chk("s5_po_latency", kp, L + 1 + P);
    chk("s5_done_latency", kd, L + 1 + P + S);

    // 6: SYSRESETREQ held for 20 cycles
    @(negedge clk_cpu); cpu_sysresetreq = 1'b1;
    lows = 0; falls = 0; prev_sys = cpu_sysreset_n;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk_cpu); #1;
      if (k == 20) cpu_sysresetreq = 1'b0;
      if (!cpu_sysreset_n) lows++;
      if (prev_sys && !cpu_sysreset_n) falls++;
      prev_sys = cpu_sysreset_n;
    end
`ifdef CPU_SYSRESETREQ_EN
    chk("s6_sys_low_cycles", lows, S);
    chk("s6_sys_pulses", falls, 1);
`else
    chk("s6_sys_low_cycles", lows, 0);
    chk("s6_sys_pulses", falls, 0);
`endif
    chk("s6_done_end", reset_done, 1);

    // Random phase, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_cpu);
      if (locked) locked = ($urandom_range(0, 149) != 0);
      else        locked = ($urandom_range(0, 3) == 0);
      host_por_req = ($urandom_range(0, 199) == 0);
      host_sys_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) cpu_sysresetreq = ~cpu_sysresetreq;
      reset = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk_cpu);
    reset = 1'b0; host_por_req = 1'b0; host_sys_req = 1'b0;
    repeat (2) @(negedge clk_cpu);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu_reset_seq.md
Name: cpu_reset_seq

Overview:
- Sits directly downstream of the CPU clock mux. Runs on the muxed CPU clock and consumes its `locked` output.
- Produces the Cortex-M power-on reset (`cpu_poreset_n`) and system reset (`cpu_sysreset_n`).
- Releases resets only after lock has been stable for a programmable time, then releases them in order: PO first, then SYS.
- Any loss of lock, or a host reset request, re-enters the sequence.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before leaving WAIT_LOCK; legal range 1..65535.
- POR_HOLD_CYCLES, 16: cycles `cpu_poreset_n` is held low after lock is qualified; legal range 1..255.
- SYS_HOLD_CYCLES, 8: additional cycles `cpu_sysreset_n` is held low after `cpu_poreset_n` releases; legal range 1..255.
- SYNC_STAGES, 2: flip-flop depth of the `locked` synchronizer; legal range 2..4.

Ports:
- clk_cpu, input, 1: CPU clock from the clock mux; the only clock.
- reset, input, 1: synchronous, active-high reset in the clk_cpu domain.
- locked, input, 1: active-high lock from the clock mux; asynchronous to clk_cpu and synchronized internally.
- host_por_req, input, 1: single-cycle pulse from the host register interface; restarts the full sequence.
- host_sys_req, input, 1: single-cycle pulse; requests a system-only reset.
- cpu_sysresetreq, input, 1: SYSRESETREQ from the CPU, level or pulse.
- cpu_poreset_n, output, 1: active-low power-on reset to the CPU.
- cpu_sysreset_n, output, 1: active-low system reset to the CPU and bus fabric.
- reset_done, output, 1: high only in RUN.
- lock_lost, output, 1: sticky flag; set when the synchronized lock falls while in PO_HOLD, SYS_HOLD or RUN; cleared only by `reset`.

Behaviour:
- Reset values (`reset` high): state = WAIT_LOCK, all counters = 0, synchronizer flops = 0.
  - cpu_poreset_n = 0, cpu_sysreset_n = 0, reset_done = 0, lock_lost = 0.
- `lock_s` is `locked` after SYNC_STAGES flip-flops. All logic below uses `lock_s` only.
- All outputs are registered and decoded from state:
  - cpu_poreset_n = 1 in SYS_HOLD and RUN.
  - cpu_sysreset_n = 1 in RUN only.
  - reset_done = 1 in RUN only.
- WAIT_LOCK:
  - Counter increments while lock_s = 1 and clears to 0 whenever lock_s = 0.
  - When the counter reaches LOCK_STABLE_CYCLES-1 with lock_s = 1, go to PO_HOLD and clear the counter.
- PO_HOLD:
  - Counts POR_HOLD_CYCLES cycles, then goes to SYS_HOLD with the counter cleared.
  - cpu_poreset_n rises on the first SYS_HOLD cycle.
- SYS_HOLD:
  - Counts SYS_HOLD_CYCLES cycles, then goes to RUN.
  - cpu_sysreset_n and reset_done rise on the first RUN cycle.
- RUN: remains until one of the events below.
- Event priority, evaluated every cycle, highest first:
  1. lock_s = 0 in any state other than WAIT_LOCK: go to WAIT_LOCK, clear counter, set lock_lost. Both resets assert on the next edge.
  2. host_por_req = 1 in any state: go to WAIT_LOCK, clear counter. lock_lost is unchanged.
  3. host_sys_req = 1 (or a qualified cpu_sysresetreq, see Optional Feature) while in RUN: go to SYS_HOLD, clear counter. cpu_poreset_n stays 1.
- host_sys_req in WAIT_LOCK, PO_HOLD or SYS_HOLD is ignored; a sequence is already in progress.
- Total latency in the clean case:
  - From `locked` rising to reset_done rising: SYNC_STAGES + LOCK_STABLE_CYCLES + POR_HOLD_CYCLES + SYS_HOLD_CYCLES cycles, ±1.
  - The bench must check this exact value with the implemented off-by-one documented in the RTL header.
- Glitch filtering: a lock_s dropout of even one cycle during WAIT_LOCK restarts the count from zero.
- Counters saturate and never wrap. Counter width is $clog2(max(LOCK_STABLE_CYCLES, POR_HOLD_CYCLES, SYS_HOLD_CYCLES)+1).
- Mid-operation `reset` forces the reset values on the next edge, regardless of state.

Optional Feature:
- Macro: CPU_SYSRESETREQ_EN.
- Defined:
  - cpu_sysresetreq is registered once and rising-edge detected.
  - A rising edge while in RUN behaves exactly like host_sys_req.
  - A level held high does not retrigger; the edge detector's previous-value flop resets to 1 so that a request already high out of reset does not fire.
- Undefined:
  - cpu_sysresetreq is ignored entirely; the CPU cannot reset itself.
  - No edge-detect logic is instantiated.

Test Plan (bench parameters LOCK_STABLE_CYCLES=8, POR_HOLD_CYCLES=4, SYS_HOLD_CYCLES=3, SYNC_STAGES=2):
1. Release reset, raise `locked` at cycle 10 and hold it -> cpu_poreset_n rises at cycle 10+2+8+4 (±1, per RTL header); cpu_sysreset_n and reset_done rise 3 cycles later; lock_lost stays 0.
2. Raise `locked` for 5 cycles, drop it for 1 cycle, then raise and hold -> no release until 8 consecutive synchronized-high cycles after the dropout; timing matches scenario 1 measured from the second rise.
3. In RUN, drop `locked` for 1 cycle -> both resets low 2–3 cycles later; reset_done = 0; lock_lost = 1 and stays 1 through the full re-sequence until `reset` is asserted.
4. In RUN, pulse host_sys_req for 1 cycle -> cpu_sysreset_n low for 3 cycles then high; cpu_poreset_n remains 1 throughout.
5. In PO_HOLD, pulse host_por_req together with host_sys_req -> state returns to WAIT_LOCK and the full sequence repeats; the host_sys_req pulse has no separate effect.
6. With CPU_SYSRESETREQ_EN defined: in RUN, hold cpu_sysresetreq high for 20 cycles -> exactly one 3-cycle cpu_sysreset_n pulse. With the macro undefined, the same stimulus produces no change on any output.
